tl_tx_tlp_buffer: RTL and testbench

// - TX TLP buffer directly upstream of the TX data-fragmentation FSM.
// - TLP-formation logic writes 1..9 locations per cycle: header (4DW) plus up to 32DW of payload.
// - The fragmentation FSM pops one location per cycle and repacks the data into 8DW DLL beats.
// - Location format: {dw[127:0], tag[1:0]}.
//   - tag[1] = SOP, tag[0] = EOP.
//   - The header sits in the first location, so FMT is at [129:127], LENGTH at [107:98], TD at [113].

---
 rtl/tl_tx_tlp_buffer_if.sv | 41 ++++
 rtl/tl_tx_tlp_buffer.sv | 116 +++++++++++
 tb/tb_tl_tx_tlp_buffer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tl_tx_tlp_buffer_if.sv
// Write/read bus between the TLP-formation logic, the TX TLP buffer and the fragmentation FSM.
// TLP_BUF_TLP_COUNT_EN adds the complete-TLP counter signals.
interface tl_tx_tlp_buffer_if #(
   parameter int unsigned LOC_WIDTH       = 130,
   parameter int unsigned NO_LOC_WR_WIDTH = 4,
   parameter int unsigned WR_DATA_WIDTH   = 1170,
   parameter int unsigned COUNT_WIDTH     = 9
);
   logic                       wr_en;
   logic [NO_LOC_WR_WIDTH-1:0] no_loc_wr;
   logic [WR_DATA_WIDTH-1:0]   wr_data;
   logic                       wr_ovf;
   logic                       rd_en;
   logic [LOC_WIDTH-1:0]       rd_data;
   logic                       rd_valid;
   logic                       rd_udf;
   logic                       empty;
   logic                       full;
   logic [COUNT_WIDTH-1:0]     count;
   logic [COUNT_WIDTH-1:0]     free_loc;
`ifdef TLP_BUF_TLP_COUNT_EN
   logic [COUNT_WIDTH-1:0]     tlp_avail;
   logic                       tlp_ready;
`endif

   modport master (
      output wr_en, no_loc_wr, wr_data, rd_en,
      input  wr_ovf, rd_data, rd_valid, rd_udf, empty, full, count, free_loc
`ifdef TLP_BUF_TLP_COUNT_EN
      , input tlp_avail, tlp_ready
`endif
   );

   modport slave (
      input  wr_en, no_loc_wr, wr_data, rd_en,
      output wr_ovf, rd_data, rd_valid, rd_udf, empty, full, count, free_loc
`ifdef TLP_BUF_TLP_COUNT_EN
      , output tlp_avail, tlp_ready
`endif
   );
endinterface

// File: rtl/tl_tx_tlp_buffer.sv
// TX TLP buffer: multi-location write (1..9 per cycle), single-location pop with 1-cycle latency.
// Define TLP_BUF_TLP_COUNT_EN to add the tlp_avail / tlp_ready complete-TLP counter.
module tl_tx_tlp_buffer (
   input logic                clk,
   input logic                arst,
   tl_tx_tlp_buffer_if.slave  bus
);
   localparam int unsigned LOC_WIDTH       = 130;
   localparam int unsigned DEPTH           = 256;
   localparam int unsigned ADDR_WIDTH      = 8;
   localparam int unsigned NO_LOC_WR_WIDTH = 4;
   localparam int unsigned MAX_LOC_WR      = 9;
   localparam int unsigned WR_DATA_WIDTH   = MAX_LOC_WR * LOC_WIDTH;
   localparam int unsigned COUNT_WIDTH     = 9;

   logic [LOC_WIDTH-1:0]       mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [COUNT_WIDTH-1:0]     count_q, count_d, free_loc_q, free_loc_d;
   logic                       empty_q, empty_d, full_q, full_d;
   logic                       rd_valid_q, rd_valid_d, wr_ovf_q, wr_ovf_d, rd_udf_q, rd_udf_d;
   logic [LOC_WIDTH-1:0]       rd_data_q, rd_data_d;
   logic [NO_LOC_WR_WIDTH-1:0] wr_n;
   logic                       wr_acc, rd_acc;
   logic [LOC_WIDTH-1:0]       wr_loc  [MAX_LOC_WR];
   logic [ADDR_WIDTH-1:0]      wr_addr [MAX_LOC_WR];
   logic [MAX_LOC_WR-1:0]      wr_we;

   always_comb begin
      wr_n   = bus.no_loc_wr;
      // Only the start-of-cycle free space counts; a same-cycle pop does not make room.
      wr_acc = bus.wr_en && (wr_n != '0) && (wr_n <= NO_LOC_WR_WIDTH'(MAX_LOC_WR)) &&
               (COUNT_WIDTH'(wr_n) <= free_loc_q);
      rd_acc = bus.rd_en && !empty_q;
      for (int unsigned i = 0; i < MAX_LOC_WR; i++) begin
         wr_loc[i]  = bus.wr_data[WR_DATA_WIDTH-1-i*LOC_WIDTH -: LOC_WIDTH];
         wr_addr[i] = wr_ptr_q + ADDR_WIDTH'(i);
         wr_we[i]   = wr_acc && (NO_LOC_WR_WIDTH'(i) < wr_n);
      end
   end

   always_comb begin
      wr_ptr_d   = wr_acc ? wr_ptr_q + ADDR_WIDTH'(wr_n) : wr_ptr_q;
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(rd_acc);
      count_d    = count_q + (wr_acc ? COUNT_WIDTH'(wr_n) : '0) - COUNT_WIDTH'(rd_acc);
      free_loc_d = COUNT_WIDTH'(DEPTH) - count_d;
      empty_d    = (count_d == '0);
      full_d     = (count_d == COUNT_WIDTH'(DEPTH));
      rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = rd_acc;
      wr_ovf_d   = bus.wr_en && !wr_acc;
      rd_udf_d   = bus.rd_en && empty_q;
   end

   // Storage is deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < MAX_LOC_WR; i++) begin
         if (wr_we[i]) mem_q[wr_addr[i]] <= wr_loc[i];
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         free_loc_q <= COUNT_WIDTH'(DEPTH);
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_ovf_q   <= 1'b0;
         rd_udf_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         free_loc_q <= free_loc_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_ovf_q   <= wr_ovf_d;
         rd_udf_q   <= rd_udf_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.wr_ovf   = wr_ovf_q;
   assign bus.rd_udf   = rd_udf_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.free_loc = free_loc_q;

`ifdef TLP_BUF_TLP_COUNT_EN
   logic [COUNT_WIDTH-1:0] tlp_avail_q, tlp_avail_d, eop_cnt;

   // EOPs written this cycle in, EOP popped this cycle out.
   always_comb begin
      eop_cnt = '0;
      for (int unsigned i = 0; i < MAX_LOC_WR; i++) begin
         eop_cnt = eop_cnt + COUNT_WIDTH'(wr_we[i] & wr_loc[i][0]);
      end
      tlp_avail_d = tlp_avail_q + eop_cnt - COUNT_WIDTH'(rd_acc & mem_q[rd_ptr_q][0]);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) tlp_avail_q <= '0;
      else      tlp_avail_q <= tlp_avail_d;
   end

   assign bus.tlp_avail = tlp_avail_q;
   assign bus.tlp_ready = (tlp_avail_q != '0);
`endif
endmodule

// File: tb/tb_tl_tx_tlp_buffer.sv
// Directed bench for tl_tx_tlp_buffer with a queue scoreboard of stored locations.
module tb_tl_tx_tlp_buffer;
   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   tl_tx_tlp_buffer_if bus ();
   tl_tx_tlp_buffer dut (.clk(clk), .arst(arst), .bus(bus));

   int            tests = 0;
   int            fails = 0;
   logic [129:0]  exp_q [$];
   int            mcount;
   int            mtlp;
   int            seq = 1;
   logic [129:0]  last_rd;
   bit            m_valid, m_ovf, m_udf;

   function automatic logic [129:0] mk_loc(input int s, input logic [1:0] tag);
      logic [31:0] v;
      v = s;
      return {v ^ 32'hDEAD_0000, ~v, v + 32'h100, v, tag};
   endfunction

   task automatic chk(input string name, input logic [129:0] obs, input logic [129:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("count",    130'(bus.count),    130'(mcount));
      chk("free_loc", 130'(bus.free_loc), 130'(256 - mcount));
      chk("empty",    130'(bus.empty),    130'(mcount == 0));
      chk("full",     130'(bus.full),     130'(mcount == 256));
      chk("wr_ovf",   130'(bus.wr_ovf),   130'(m_ovf));
      chk("rd_valid", 130'(bus.rd_valid), 130'(m_valid));
      chk("rd_udf",   130'(bus.rd_udf),   130'(m_udf));
      chk("rd_data",  bus.rd_data,        last_rd);
`ifdef TLP_BUF_TLP_COUNT_EN
      chk("tlp_avail", 130'(bus.tlp_avail), 130'(mtlp));
      chk("tlp_ready", 130'(bus.tlp_ready), 130'(mtlp != 0));
`endif
   endtask

   task automatic clear_model();
      exp_q.delete();
      mcount  = 0;
      mtlp    = 0;
      last_rd = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.wr_en     = 1'b0;
      bus.no_loc_wr = '0;
      bus.wr_data   = '0;
      bus.rd_en     = 1'b0;
   endtask

   task automatic do_reset();
      arst = 1'b1;
      idle_inputs();
      clear_model();
      @(posedge clk);
      #1;
      check_outputs();
      arst = 1'b0;
   endtask

   // One clock: drive write/read, update scoreboard, check all outputs after the edge.
   task automatic step(input bit wr, input int n, input logic [17:0] tags, input bit rd);
      logic [1169:0] d;
      logic [129:0]  loc;
      bit            acc_w, acc_r;
      d = '0;
      for (int i = 0; i < n && i < 9; i++) begin
         d[1169-i*130 -: 130] = mk_loc(seq + i, tags[2*i +: 2]);
      end
      bus.wr_en     = wr;
      bus.no_loc_wr = 4'(n);
      bus.wr_data   = d;
      bus.rd_en     = rd;
      acc_w   = wr && n >= 1 && n <= 9 && n <= 256 - mcount;
      acc_r   = rd && mcount != 0;
      m_valid = acc_r;
      m_ovf   = wr && !acc_w;
      m_udf   = rd && mcount == 0;
      if (acc_r) begin
         loc     = exp_q.pop_front();
         last_rd = loc;
         if (loc[0]) mtlp--;
         mcount--;
      end
      if (acc_w) begin
         for (int i = 0; i < n; i++) begin
            loc = mk_loc(seq + i, tags[2*i +: 2]);
            exp_q.push_back(loc);
            if (loc[0]) mtlp++;
         end
         mcount += n;
      end
      seq += 16;
      @(posedge clk);
      #1;
      idle_inputs();
      check_outputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arst = 1'b0;
      idle_inputs();
      clear_model();
      #2;
      do_reset();

      // Three-location TLP, tags 10/00/01, then drain.
      step(1, 3, 18'h12, 0);
      for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
      step(0, 0, '0, 0);

      // Fill to 250, overflow by 9, then exactly fill.
      for (int i = 0; i < 27; i++) step(1, 9, '0, 0);
      step(1, 7, '0, 0);
      step(1, 9, '0, 0);
      step(0, 0, '0, 0);
      step(1, 0, '0, 0);
      step(1, 10, '0, 0);
      step(1, 6, '0, 0);
      step(1, 1, '0, 0);
      step(0, 0, '0, 1);

      // Move both pointers to 252, then a write straddling 255 -> 0.
      do_reset();
      for (int i = 0; i < 252; i++) begin
         step(1, 1, '0, 0);
         step(0, 0, '0, 1);
      end
      step(1, 9, 18'h0C003, 0);
      for (int i = 0; i < 9; i++) step(0, 0, '0, 1);

      // Simultaneous write and pop at count 5.
      do_reset();
      step(1, 5, '0, 0);
      step(1, 4, '0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      step(0, 0, '0, 0);

      // Async reset in the middle of an in-flight write+read.
      step(1, 4, '0, 0);
      bus.wr_en     = 1'b1;
      bus.no_loc_wr = 4'd2;
      bus.wr_data   = {mk_loc(777, 2'b11), 1040'(0)};
      bus.rd_en     = 1'b1;
      #2;
      arst = 1'b1;
      clear_model();
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      idle_inputs();
      arst = 1'b0;
      step(0, 0, '0, 1);

      // Complete-TLP counting: two single-location TLPs, pop, then pop+EOP write together.
      do_reset();
      step(1, 2, 18'h0F, 0);
      step(0, 0, '0, 1);
      step(1, 1, 18'h03, 1);
      step(0, 0, '0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
